monty_reduce_u: RTL and testbench
=================================

# monty_reduce_u

Iterative word-serial Montgomery reduction for moduli of the form q = qH·2^R + 1, with R = LOGQ − LOGQH. It takes a double-width product P and returns C ≡ P·2^(−LOGQ) mod q with C in [0, 2q). It sits directly upstream of the final conditional-subtraction stage, which reduces C into [0, q). Because q ≡ 1 mod 2^W, no precomputed inverse is needed: each step uses m = (−acc) mod 2^W.

## Interface
Parameters:
- LOGQ, 64, modulus width; LOGQ % W == 0 required
- LOGQH, 17, width of qH; R = LOGQ − LOGQH
- W, 16, reduction digit width per iteration; 1 ≤ W ≤ R required
- K (localparam), LOGQ/W, iteration count

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  P/qH valid
- in_ready  out  1  block can accept
- P  in  2·LOGQ  product to reduce; precondition P < q·2^LOGQ
- qH  in  LOGQH  modulus high part; precondition qH[LOGQH−1] = 0, so 2q < 2^LOGQ
- out_valid  out  1  C valid
- out_ready  in  1  consumer accepts C
- C  out  LOGQ  reduced result in [0, 2q)

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - acc: 2·LOGQ bits
  - qH_r: LOGQH bits
  - cnt: ⌈log2 K⌉ bits, minimum 1
  - C_r: LOGQ bits
- Output assignments: in_ready = (state == IDLE); out_valid = (state == DONE); C = C_r.
- IDLE: on in_valid & in_ready, set acc ← P, qH_r ← qH, cnt ← 0, and go to RUN.
- RUN, one step per cycle:
  - m = (2^W − acc[W−1:0]) mod 2^W.
  - acc ← (acc + m·qH_r·2^R + m) >> W.
  - The low W bits of the sum are always zero, so the shift is exact.
  - Width rule: the sum is evaluated in 2·LOGQ+1 bits; the top bit is always zero under the preconditions.
  - cnt ← cnt + 1.
  - When cnt == K−1, the step result's low LOGQ bits are written to C_r and the state goes to DONE. acc is not used afterwards.
- DONE:
  - C_r is held stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE.
- Inputs are ignored outside IDLE. qH may change freely after acceptance because qH_r is used.
- Precondition violations (P ≥ q·2^LOGQ, or qH MSB set) give an undefined C. The FSM still completes normally.
- Reset: state ← IDLE, cnt ← 0, C_r ← 0. acc and qH_r need no reset.

## Timing
- Reset values, in the cycle after rst is sampled high: in_ready = 1, out_valid = 0, C = 0.
- Latency:
  - P accepted at edge t.
  - K RUN steps occur at edges t+1 … t+K.
  - out_valid is high from edge t+K.
  - With W = LOGQ, K = 1 and out_valid rises one cycle after acceptance.
- Handshake:
  - Transfer occurs at a clock edge where valid & ready.
  - out_valid, once high, stays high with C unchanged until transfer.
- Throughput:
  - in_ready returns high the cycle after the output transfer.
  - With out_ready held at 1, one operation completes per K+2 cycles.
- rst mid-RUN or mid-DONE aborts the operation. Any pending result is dropped with no output transfer.
- rst together with in_valid in IDLE: reset wins and nothing is accepted.

## Test plan
Bench parameters: LOGQ=8, LOGQH=3, W=4 (R=5, K=2), qH=3'b011 (q=97).
- Basic:
  - Stimulus: P=1, out_ready=1.
  - Required: out_valid exactly 2 cycles after acceptance, C=36 (36·256 ≡ 1 mod 97). Intermediate acc after step 1 = 91.
- Montgomery identity:
  - Stimulus: P=256.
  - Required: C=1. m=0 on both steps, so this also checks the zero-low-digit path.
- Upper bound:
  - Stimulus: P=24831 (= q·2^8 − 1).
  - Required: C=158, which is in [97, 194).
  - Chaining C into the correction stage must give 61.
- Backpressure:
  - Stimulus: P=1, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid and C=36 held stable throughout. in_ready stays 0 until the cycle after transfer. A second in_valid offered during the stall is not accepted.
- Reset mid-operation:
  - Stimulus: accept P=24831, assert rst one cycle later.
  - Required: next cycle in_ready=1, out_valid=0, C=0, and no output transfer. A subsequent P=1 yields C=36.
- Back-to-back:
  - Stimulus: in_valid and out_ready held at 1, P sequence 1, 256, 0.
  - Required: outputs 36, 1, 0 in order, with acceptances spaced exactly K+2 = 4 cycles apart.

Source files
------------

// File: rtl/monty_reduce_u.sv
// Word-serial Montgomery reduction for q = qH*2^R + 1.
// Returns C = P*2^-LOGQ mod q in [0, 2q), one W-bit digit retired per cycle.
module monty_reduce_u #(
  parameter int LOGQ  = 64,
  parameter int LOGQH = 17,
  parameter int W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LOGQ-1:0]   P,
  input  logic [LOGQH-1:0]    qH,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LOGQ-1:0]     C
);

  localparam int R  = LOGQ - LOGQH;
  localparam int K  = LOGQ / W;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int AW = 2 * LOGQ;
  localparam int SW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(K - 1);

  logic [1:0]       state_reg;
  logic [AW-1:0]    acc_reg;
  logic [LOGQH-1:0] qh_reg;
  logic [CW-1:0]    cnt_reg;
  logic [LOGQ-1:0]  c_reg;

  logic [W-1:0]     m_next;
  logic [SW-1:0]    sum_next;
  logic [AW-1:0]    acc_next;

  // q = 1 mod 2^W, so -acc mod 2^W is the digit that clears the low W bits.
  always_comb begin
    m_next   = W'(0) - acc_reg[W-1:0];
    sum_next = SW'(acc_reg)
             + ((SW'(m_next) * SW'(qh_reg)) << R)
             + SW'(m_next);
    acc_next = AW'(sum_next >> W);
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign C         = c_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      c_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            acc_reg   <= P;
            qh_reg    <= qH;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_CNT) begin
            c_reg     <= acc_next[LOGQ-1:0];
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monty_reduce_u.sv
// Directed bench for monty_reduce_u at LOGQ=8, LOGQH=3, W=4 with q = 97.
// Expected values are hand-computed Montgomery results (x * 2^-8 mod 97, in [0, 194)).
module tb_monty_reduce_u;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] P;
  logic [2:0]  qH;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  C;

  int total;
  int bad;

  monty_reduce_u #(.LOGQ(8), .LOGQH(3), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .qH        (qH),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer p with out_ready=1; return C and the cycles from acceptance to out_valid.
  task automatic run_op(input logic [15:0] p, output logic [7:0] c, output int lat);
    P         = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    qH       = 3'b111;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    c = C;
    @(negedge clk);
    qH = 3'b011;
  endtask

  logic [7:0]  c_obs;
  int          lat;
  logic [15:0] vec [3];
  logic [7:0]  res [3];
  int          acc_t [3];
  int          ai;
  int          ri;
  bit          took;

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    P         = 16'd1;
    qH        = 3'b011;

    // Reset, with in_valid asserted: nothing may be accepted.
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_C", 64'(C), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'(in_ready), 64'd1);

    // Basic: P=1, including the intermediate accumulator after step 1.
    P         = 16'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("basic_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("basic_acc_step1", 64'(dut.acc_reg), 64'd91);
    chk("basic_not_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("basic_out_valid", 64'(out_valid), 64'd1);
    chk("basic_C", 64'(C), 64'd36);
    @(negedge clk);
    chk("basic_released", 64'(out_valid), 64'd0);
    chk("basic_in_ready", 64'(in_ready), 64'd1);

    // Montgomery identity, zero-digit path.
    run_op(16'd256, c_obs, lat);
    chk("ident_C", 64'(c_obs), 64'd1);
    chk("ident_latency", 64'(lat), 64'd2);

    // Upper bound of the input range, then final correction.
    run_op(16'd24831, c_obs, lat);
    chk("upper_C", 64'(c_obs), 64'd158);
    chk("upper_corrected", 64'((c_obs >= 8'd97) ? (c_obs - 8'd97) : c_obs), 64'd61);

    // Backpressure: hold the result for 5 cycles while another input is offered.
    P         = 16'd1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd2);
    P        = 16'd256;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_C", 64'(C), 64'd36);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_transfer_done", 64'(out_valid), 64'd0);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_no_stall_accept", 64'(in_ready), 64'd1);

    // Reset one cycle after accepting P.
    P         = 16'd24831;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_C", 64'(C), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_output", 64'(out_valid), 64'd0);
    end
    run_op(16'd1, c_obs, lat);
    chk("rst_after_C", 64'(c_obs), 64'd36);
    chk("rst_after_latency", 64'(lat), 64'd2);

    // Back-to-back with in_valid and out_ready held high.
    vec[0]    = 16'd1;
    vec[1]    = 16'd256;
    vec[2]    = 16'd0;
    ai        = 0;
    ri        = 0;
    P         = vec[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      took = 1'b0;
      if (in_ready && ai < 3) begin
        acc_t[ai] = cyc;
        took      = 1'b1;
      end
      if (out_valid && ri < 3) begin
        res[ri] = C;
        ri++;
      end
      @(negedge clk);
      if (took) begin
        ai++;
        if (ai < 3) P = vec[ai];
        else in_valid = 1'b0;
      end
      if (ri == 3) break;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(ai), 64'd3);
    chk("b2b_results", 64'(ri), 64'd3);
    chk("b2b_C0", 64'(res[0]), 64'd36);
    chk("b2b_C1", 64'(res[1]), 64'd1);
    chk("b2b_C2", 64'(res[2]), 64'd0);
    chk("b2b_gap01", 64'(acc_t[1] - acc_t[0]), 64'd4);
    chk("b2b_gap12", 64'(acc_t[2] - acc_t[1]), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
